ram_2rw_arbiter: RTL
====================

Name: ram_2RW_arbiter

Overview:
- Shares one 2RW behavioural RAM (ports a and b, 1-cycle read latency, read-first per port) between REQ_NB requesters.
- Grants up to two requests per cycle using round-robin priority.
- Prevents cross-port same-address hazards.
- Routes read data back to the originating requester.
- Sits between client engines (e.g. key/ciphertext buffers) and the RAM core.

Parameters:
- WIDTH, 32, data width.
- DEPTH, 512, RAM words; AW = $clog2(DEPTH).
- REQ_NB, 4, number of requesters (2..8).

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous reset, active-high
- req_vld  in  REQ_NB  request valid, one bit per requester
- req_rdy  out  REQ_NB  request accepted this cycle (grant)
- req_wen  in  REQ_NB  1 = write, 0 = read
- req_add  in  REQ_NB*AW  addresses, requester i at [i*AW +: AW]
- req_wr_data  in  REQ_NB*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
- rsp_vld  out  REQ_NB  read data valid for requester i
- rsp_rd_data  out  REQ_NB*WIDTH  read data, requester i slice
- a_en, a_wen  out  1  RAM port a controls
- a_add  out  AW  RAM port a address
- a_wr_data  out  WIDTH  RAM port a write data
- a_rd_data  in  WIDTH  RAM port a read data
- b_en, b_wen, b_add, b_wr_data, b_rd_data  same as port a, for port b

Behaviour:
- State:
  - rr_ptr[$clog2(REQ_NB)-1:0], the highest-priority index.
  - Per-port response tag registers: a_rsp_vld, a_rsp_id, b_rsp_vld, b_rsp_id.
- Grant, combinational in cycle t:
  - Scan req_vld from rr_ptr upward with wrap.
  - First valid requester is G0, mapped to port a. Next valid requester is G1, mapped to port b.
- Conflict rule:
  - If add(G1) == add(G0) and (wen(G0) | wen(G1)), G1 is not granted that cycle.
  - G1 stays pending; no third requester is substituted.
  - Two reads to the same address are both granted.
- Outputs in cycle t:
  - req_rdy[i] = 1 only for granted requesters.
  - Handshake completes when req_vld & req_rdy. Requesters must hold vld/wen/add/data stable until rdy.
  - req_rdy never asserts without req_vld.
- Port drive in cycle t: a_en = G0 exists; a_wen/a_add/a_wr_data = G0 fields. Port b same with G1. Ports are zero when unused.
- Pointer update at t+1:
  - rr_ptr <= (last granted index + 1) mod REQ_NB.
  - Unchanged if nothing granted.
- Read response:
  - A read granted in cycle t gives rsp_vld[id] = 1 in cycle t+1.
  - rsp_rd_data[id] = a_rd_data or b_rd_data of the port used in cycle t.
  - Total latency 1 cycle; no response backpressure.
  - Writes produce no response.
  - A requester granted on both ports is impossible (one grant per requester per cycle).
- Read-first: a read and write to the same address on the same port cannot occur. A write at t followed by a read at t+1 returns the new data.
- Fairness: every requester held valid is granted within REQ_NB cycles.
- Reset:
  - rr_ptr = 0; req_rdy = 0; a_en = b_en = 0; rsp_vld = 0; rsp_rd_data = 0 (unused slices also 0).
  - A read granted in cycle t with s_rst high at t+1 has its response dropped; rsp_vld stays 0.
  - No grants while s_rst = 1.

Test Plan:
- Single read: write 0xCAFE0001 to add 5 via req 0, then read add 5 via req 2 -> req_rdy[2] same cycle; rsp_vld[2] = 1 and rsp_rd_data[2] = 0xCAFE0001 one cycle later; other rsp_vld = 0.
- Dual grant: reqs 0–3 all reading distinct addresses 10–13 with rr_ptr = 0 -> cycle 0 grants 0 (a) and 1 (b); cycle 1 grants 2 and 3; each response arrives the cycle after its grant with the correct data.
- Hazard: req 1 writes 0x11 to add 7 while req 2 reads add 7, rr_ptr = 1 -> only req 1 granted; req 2 granted next cycle and returns 0x11. Two reads of add 7 -> both granted the same cycle.
- Round-robin: all 4 requesters continuously valid for 8 cycles -> grant order (0,1), (2,3), (0,1), …; rr_ptr wraps 0→2→0; each requester receives 4 grants.
- Reset mid-operation: read granted at cycle t, s_rst high at t+1 -> rsp_vld stays 0, a_en = b_en = 0. After release, rr_ptr = 0 and the first grant goes to the lowest valid index.
- Idle and single requester: only req 3 valid every cycle -> granted every cycle on port a, b_en = 0, rr_ptr stays 0.

Source files
------------

// File: rtl/ram_2rw_arbiter.sv
// Round-robin arbiter that shares one 2RW RAM (ports a and b) between REQ_NB requesters.
// Up to two grants per cycle. A same-address pair that includes a write is split across cycles.
module ram_2rw_arbiter #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 512,
   parameter  int REQ_NB = 4,
   localparam int AW     = $clog2(DEPTH),
   localparam int IW     = $clog2(REQ_NB)
) (
   input  logic                    i_clk,
   input  logic                    i_s_rst,
   input  logic [REQ_NB-1:0]       i_req_vld,
   output logic [REQ_NB-1:0]       o_req_rdy,
   input  logic [REQ_NB-1:0]       i_req_wen,
   input  logic [REQ_NB*AW-1:0]    i_req_add,
   input  logic [REQ_NB*WIDTH-1:0] i_req_wr_data,
   output logic [REQ_NB-1:0]       o_rsp_vld,
   output logic [REQ_NB*WIDTH-1:0] o_rsp_rd_data,
   output logic                    o_a_en,
   output logic                    o_a_wen,
   output logic [AW-1:0]           o_a_add,
   output logic [WIDTH-1:0]        o_a_wr_data,
   input  logic [WIDTH-1:0]        i_a_rd_data,
   output logic                    o_b_en,
   output logic                    o_b_wen,
   output logic [AW-1:0]           o_b_add,
   output logic [WIDTH-1:0]        o_b_wr_data,
   input  logic [WIDTH-1:0]        i_b_rd_data
);

   logic [AW-1:0]    w_add   [REQ_NB];
   logic [WIDTH-1:0] w_wdata [REQ_NB];

   logic [IW-1:0]    r_rr_ptr;
   logic             r_a_rsp_vld;
   logic [IW-1:0]    r_a_rsp_id;
   logic             r_b_rsp_vld;
   logic [IW-1:0]    r_b_rsp_id;

   logic             w_g0_vld;
   logic [IW-1:0]    w_g0_id;
   logic             w_g1_vld;
   logic [IW-1:0]    w_g1_id;
   logic [IW-1:0]    w_idx;
   logic             w_hazard;
   logic             w_gnt0;
   logic             w_gnt1;

   // Modulo REQ_NB for values below 2*REQ_NB, without a divider.
   function automatic logic [IW-1:0] f_wrap(input int val);
      int v;
      v = val;
      if (v >= REQ_NB) v = v - REQ_NB;
      return IW'(v);
   endfunction

   for (genvar i = 0; i < REQ_NB; i++) begin : g_unpack
      assign w_add[i]   = i_req_add[i*AW +: AW];
      assign w_wdata[i] = i_req_wr_data[i*WIDTH +: WIDTH];
   end

   // The first two valid requesters at or after the pointer, in wrap order, become G0 and G1.
   always_comb begin
      w_g0_vld = 1'b0;
      w_g0_id  = '0;
      w_g1_vld = 1'b0;
      w_g1_id  = '0;
      w_idx    = '0;
      for (int k = 0; k < REQ_NB; k++) begin
         w_idx = f_wrap(int'(r_rr_ptr) + k);
         if (i_req_vld[w_idx]) begin
            if (!w_g0_vld) begin
               w_g0_vld = 1'b1;
               w_g0_id  = w_idx;
            end else if (!w_g1_vld) begin
               w_g1_vld = 1'b1;
               w_g1_id  = w_idx;
            end
         end
      end
   end

   // G1 waits when it shares an address with G0 and either side writes. No other requester takes its place.
   assign w_hazard = (w_add[w_g0_id] == w_add[w_g1_id]) &&
                     (i_req_wen[w_g0_id] || i_req_wen[w_g1_id]);
   assign w_gnt0   = w_g0_vld && !i_s_rst;
   assign w_gnt1   = w_g1_vld && !w_hazard && !i_s_rst;

   always_comb begin
      o_req_rdy = '0;
      if (w_gnt0) o_req_rdy[w_g0_id] = 1'b1;
      if (w_gnt1) o_req_rdy[w_g1_id] = 1'b1;

      o_a_en      = w_gnt0;
      o_a_wen     = w_gnt0 && i_req_wen[w_g0_id];
      o_a_add     = w_gnt0 ? w_add[w_g0_id]   : '0;
      o_a_wr_data = w_gnt0 ? w_wdata[w_g0_id] : '0;

      o_b_en      = w_gnt1;
      o_b_wen     = w_gnt1 && i_req_wen[w_g1_id];
      o_b_add     = w_gnt1 ? w_add[w_g1_id]   : '0;
      o_b_wr_data = w_gnt1 ? w_wdata[w_g1_id] : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_s_rst) begin
         r_rr_ptr    <= '0;
         r_a_rsp_vld <= 1'b0;
         r_a_rsp_id  <= '0;
         r_b_rsp_vld <= 1'b0;
         r_b_rsp_id  <= '0;
      end else begin
         if (w_gnt1)      r_rr_ptr <= f_wrap(int'(w_g1_id) + 1);
         else if (w_gnt0) r_rr_ptr <= f_wrap(int'(w_g0_id) + 1);
         r_a_rsp_vld <= w_gnt0 && !i_req_wen[w_g0_id];
         r_a_rsp_id  <= w_g0_id;
         r_b_rsp_vld <= w_gnt1 && !i_req_wen[w_g1_id];
         r_b_rsp_id  <= w_g1_id;
      end
   end

   // Responses are masked during reset, so a read granted just before reset delivers nothing.
   always_comb begin
      o_rsp_vld     = '0;
      o_rsp_rd_data = '0;
      if (!i_s_rst) begin
         if (r_a_rsp_vld) begin
            o_rsp_vld[r_a_rsp_id]                   = 1'b1;
            o_rsp_rd_data[r_a_rsp_id*WIDTH +: WIDTH] = i_a_rd_data;
         end
         if (r_b_rsp_vld) begin
            o_rsp_vld[r_b_rsp_id]                   = 1'b1;
            o_rsp_rd_data[r_b_rsp_id*WIDTH +: WIDTH] = i_b_rd_data;
         end
      end
   end

endmodule
